teclado_codificador: RTL and testbench

Matrix-keypad scanner and encoder for the 4x4 keypad. It drives the columns one at a time, samples the rows, debounces press and release, and outputs a 4-bit key code on `a`, `b`, `c`, `d` with a data-valid level and a one-cycle new-key strobe. It is the encoding end of the keypad path: its `a..d` outputs feed the keypad decoder's `a..d` inputs directly.

---
 rtl/teclado_pkg.sv | 25 ++
 rtl/teclado_sync.sv | 26 ++
 rtl/teclado_codificador.sv | 143 ++++++++++++++
 tb/tb_teclado_codificador.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner/encoder.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } teclado_estado_t;

  localparam int         COD_W           = 4;
  localparam logic [3:0] COL_RESET       = 4'b1110;
  localparam logic [3:0] FILAS_INACTIVAS = 4'b1111;

  // Index of the lowest-numbered low bit; the lowest row wins on multiple presses.
  function automatic logic [1:0] indice_bajo(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!v[2'(3 - i)]) idx = 2'(3 - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/teclado_sync.sv
// 4-bit two-flop synchronizer for the keypad rows; resets to all-high (no key).
module teclado_sync
  import teclado_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_filas,
  output logic [3:0] o_filas
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= FILAS_INACTIVAS;
      r_sync <= FILAS_INACTIVAS;
    end else begin
      r_meta <= i_filas;
      r_sync <= r_meta;
    end
  end

  assign o_filas = r_sync;

endmodule

// File: rtl/teclado_codificador.sv
// 4x4 matrix-keypad scanner, debouncer and encoder (code = row*4 + col).
// Define TECLADO_SYNC_EN to pass the rows through a 2-flop synchronizer.
module teclado_codificador
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       dato_valido,
  output logic       tecla_nueva
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE);
  localparam logic [SLOT_W-1:0] SLOT_ULT = SLOT_W'(SCAN_DIV - 1);
  // The evaluating cycle counts as the first stable one, hence DEBOUNCE-2.
  localparam logic [DEB_W-1:0]  DEB_ULT  = DEB_W'(DEBOUNCE - 2);

  logic [3:0] w_fs;

`ifdef TECLADO_SYNC_EN
  teclado_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_filas (filas),
    .o_filas (w_fs)
  );
`else
  assign w_fs = filas;
`endif

  teclado_estado_t   r_estado, w_estado;
  logic [3:0]        r_col, w_col;
  logic [SLOT_W-1:0] r_slot, w_slot;
  logic [DEB_W-1:0]  r_deb, w_deb;
  logic [3:0]        r_captura, w_captura;
  logic [COD_W-1:0]  r_codigo, w_codigo;
  logic              r_valido, w_valido;
  logic              r_nueva, w_nueva;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado  <= SCAN;
      r_col     <= COL_RESET;
      r_slot    <= '0;
      r_deb     <= '0;
      r_captura <= FILAS_INACTIVAS;
      r_codigo  <= '0;
      r_valido  <= 1'b0;
      r_nueva   <= 1'b0;
    end else begin
      r_estado  <= w_estado;
      r_col     <= w_col;
      r_slot    <= w_slot;
      r_deb     <= w_deb;
      r_captura <= w_captura;
      r_codigo  <= w_codigo;
      r_valido  <= w_valido;
      r_nueva   <= w_nueva;
    end
  end

  always_comb begin
    w_estado  = r_estado;
    w_col     = r_col;
    w_slot    = r_slot;
    w_deb     = r_deb;
    w_captura = r_captura;
    w_codigo  = r_codigo;
    w_valido  = r_valido;
    w_nueva   = 1'b0;
    case (r_estado)
      SCAN: begin
        // Rows are only looked at in the last slot cycle so synchronizer lag settles.
        if (r_slot == SLOT_ULT) begin
          if (w_fs != FILAS_INACTIVAS) begin
            w_captura = w_fs;
            w_deb     = '0;
            w_estado  = DEB_PRESS;
          end else begin
            w_slot = '0;
            w_col  = {r_col[2:0], r_col[3]};
          end
        end else begin
          w_slot = r_slot + SLOT_W'(1);
        end
      end
      DEB_PRESS: begin
        if (w_fs == r_captura) begin
          if (r_deb == DEB_ULT) begin
            w_estado = HELD;
            w_codigo = {indice_bajo(r_captura), indice_bajo(r_col)};
            w_valido = 1'b1;
            w_nueva  = 1'b1;
          end else begin
            w_deb = r_deb + DEB_W'(1);
          end
        end else begin
          w_estado = SCAN;
          w_slot   = '0;
        end
      end
      HELD: begin
        if (w_fs == FILAS_INACTIVAS) begin
          w_estado = DEB_REL;
          w_deb    = '0;
        end
      end
      DEB_REL: begin
        if (w_fs == FILAS_INACTIVAS) begin
          if (r_deb == DEB_ULT) begin
            w_estado = SCAN;
            w_valido = 1'b0;
            w_slot   = '0;
            w_col    = {r_col[2:0], r_col[3]};
          end else begin
            w_deb = r_deb + DEB_W'(1);
          end
        end else begin
          w_estado = HELD;
        end
      end
      default: w_estado = SCAN;
    endcase
  end

  assign columnas    = r_col;
  assign a           = r_codigo[3];
  assign b           = r_codigo[2];
  assign c           = r_codigo[1];
  assign d           = r_codigo[0];
  assign dato_valido = r_valido;
  assign tecla_nueva = r_nueva;

endmodule

// File: tb/tb_teclado_codificador.sv
// Self-checking bench for teclado_codificador with a cycle-level reference model.
module tb_teclado_codificador;

  localparam int SD = 4;
  localparam int DB = 8;
`ifdef TECLADO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic       a, b, c, d;
  logic       dato_valido, tecla_nueva;
  logic [15:0] teclas = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulsos = 0;

  always #5 clk = ~clk;

  teclado_codificador #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .filas       (filas),
    .columnas    (columnas),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .dato_valido (dato_valido),
    .tecla_nueva (tecla_nueva)
  );

  // Keypad: row r is pulled low while column c is driven low and key (r,c) is down.
  always_comb begin
    filas = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (teclas[r*4+k] && !columnas[k]) filas[r] = 1'b0;
  end

  // Reference model: column index, slot position and run length of stable cycles.
  typedef enum int {M_BARRIDO, M_PULSA, M_MANT, M_SUELTA} m_fase_t;
  m_fase_t    m_fase = M_BARRIDO;
  int         m_col = 0, m_slot = 0, m_run = 0;
  logic [3:0] m_pat = 4'hF, m_cod = 4'h0, m_q1 = 4'hF, m_q2 = 4'hF;
  logic       m_val = 1'b0, m_new = 1'b0;

  function automatic int fila_baja(input logic [3:0] p);
    for (int r = 0; r < 4; r++) if (!p[r]) return r;
    return 0;
  endfunction

  task automatic paso_modelo();
    logic [3:0] fs;
`ifdef TECLADO_SYNC_EN
    fs = m_q2;
`else
    fs = filas;
`endif
    if (!rst_n) begin
      m_fase = M_BARRIDO; m_col = 0; m_slot = 0; m_run = 0;
      m_cod = 4'h0; m_val = 1'b0; m_new = 1'b0;
      m_q1 = 4'hF; m_q2 = 4'hF;
      return;
    end
    m_new = 1'b0;
    case (m_fase)
      M_BARRIDO: begin
        if (m_slot == SD - 1) begin
          if (fs != 4'hF) begin
            m_pat = fs; m_run = 1; m_fase = M_PULSA;
          end else begin
            m_slot = 0; m_col = (m_col + 1) % 4;
          end
        end else m_slot++;
      end
      M_PULSA: begin
        if (fs == m_pat) begin
          m_run++;
          if (m_run == DB) begin
            m_fase = M_MANT;
            m_cod = 4'(fila_baja(m_pat) * 4 + m_col);
            m_val = 1'b1; m_new = 1'b1;
          end
        end else begin
          m_fase = M_BARRIDO; m_slot = 0;
        end
      end
      M_MANT: begin
        if (fs == 4'hF) begin m_fase = M_SUELTA; m_run = 1; end
      end
      M_SUELTA: begin
        if (fs == 4'hF) begin
          m_run++;
          if (m_run == DB) begin
            m_fase = M_BARRIDO; m_val = 1'b0; m_slot = 0;
            m_col = (m_col + 1) % 4;
          end
        end else m_fase = M_MANT;
      end
      default: m_fase = M_BARRIDO;
    endcase
    m_q2 = m_q1;
    m_q1 = filas;
  endtask

  task automatic tick();
    logic [9:0] got, exp;
    logic [3:0] uno;
    @(negedge clk);
    paso_modelo();
    @(posedge clk);
    #1;
    uno = 4'b0001;
    got = {columnas, a, b, c, d, dato_valido, tecla_nueva};
    exp = {~(uno << m_col), m_cod, m_val, m_new};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL ciclo t=%0t got col/abcd/dv/tn=%b expected=%b", $time, got, exp);
    end
    if (tecla_nueva === 1'b1) n_pulsos++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string nombre, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", nombre, got, exp);
    end
  endtask

  task automatic check_reset(input string nombre);
    check({nombre, "_col"}, int'(columnas), 4'b1110);
    check({nombre, "_abcd"}, int'({a, b, c, d}), 0);
    check({nombre, "_dv"}, int'(dato_valido), 0);
    check({nombre, "_tn"}, int'(tecla_nueva), 0);
  endtask

  typedef struct {
    logic [15:0] mask;
    int          hold;
    logic [3:0]  exp_cod;
  } vec_t;

  vec_t tabla[6];

  initial begin
    int p0, j;
    logic dv_min;

    tabla[0] = '{16'h0001 << (2*4+1), 60, 4'b1001};
    tabla[1] = '{16'h0001 << (0*4+0), 60, 4'b0000};
    tabla[2] = '{16'h0001 << (3*4+3), 60, 4'b1111};
    tabla[3] = '{(16'h0001 << (1*4+2)) | (16'h0001 << (3*4+2)), 60, 4'b0110};
    tabla[4] = '{16'h0001 << (0*4+3), 60, 4'b0011};
    tabla[5] = '{16'h0001 << (3*4+0), 60, 4'b1100};

    rst_n = 1'b0;
    ticks(2);
    check_reset("reset_ini");
    rst_n = 1'b1;
    ticks(3);

    for (int i = 0; i < 6; i++) begin
      p0 = n_pulsos;
      teclas = tabla[i].mask;
      ticks(tabla[i].hold);
      check($sformatf("v%0d_dv_held", i), int'(dato_valido), 1);
      teclas = '0;
      ticks(30);
      check($sformatf("v%0d_pulsos", i), n_pulsos - p0, 1);
      check($sformatf("v%0d_abcd", i), int'({a, b, c, d}), int'(tabla[i].exp_cod));
      check($sformatf("v%0d_dv_rel", i), int'(dato_valido), 0);
    end

    // Single press with measured release latency.
    p0 = n_pulsos;
    teclas = 16'h0001 << (2*4+1);
    ticks(200);
    check("single_dv", int'(dato_valido), 1);
    teclas = '0;
    j = 0;
    while (dato_valido === 1'b1 && j < 40) begin tick(); j++; end
    check("single_rel_lat", j, DB + SYNC_LAT);
    check("single_pulsos", n_pulsos - p0, 1);
    check("single_abcd", int'({a, b, c, d}), 9);
    ticks(10);

    // Bouncy press on (3,3).
    p0 = n_pulsos;
    teclas = 16'h8000;
    for (int i = 0; i < 10; i++) begin
      ticks(3);
      teclas[15] = ~teclas[15];
    end
    teclas[15] = 1'b1;
    ticks(60);
    check("bounce_pulsos", n_pulsos - p0, 1);
    check("bounce_abcd", int'({a, b, c, d}), 15);
    teclas = '0;
    ticks(30);

    // Isolated 5-cycle glitch on (0,0).
    p0 = n_pulsos;
    teclas = 16'h0001;
    ticks(5);
    teclas = '0;
    ticks(40);
    check("glitch_pulsos", n_pulsos - p0, 0);
    check("glitch_dv", int'(dato_valido), 0);

    // Bouncy release on (1,1).
    teclas = 16'h0001 << 5;
    ticks(60);
    check("brel_dv_held", int'(dato_valido), 1);
    p0 = n_pulsos;
    dv_min = 1'b1;
    teclas = '0;
    for (int i = 0; i < 3; i++) begin tick(); dv_min &= dato_valido; end
    teclas = 16'h0001 << 5;
    for (int i = 0; i < 4; i++) begin tick(); dv_min &= dato_valido; end
    teclas = '0;
    for (int i = 0; i < 3; i++) begin tick(); dv_min &= dato_valido; end
    check("brel_dv_stay", int'(dv_min), 1);
    ticks(30);
    check("brel_pulsos", n_pulsos - p0, 0);
    check("brel_dv_rel", int'(dato_valido), 0);

    // Reset while in HELD.
    teclas = 16'h0001 << (2*4+1);
    j = 0;
    while (dato_valido !== 1'b1 && j < 60) begin tick(); j++; end
    check("rheld_wait", int'(dato_valido), 1);
    ticks(3);
    rst_n = 1'b0;
    tick();
    check_reset("rheld");
    rst_n = 1'b1;
    teclas = '0;
    ticks(4);
    check("rheld_col1", int'(columnas), 4'b1101);
    ticks(20);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      int kind, hold;
      kind = $urandom_range(0, 4);
      hold = $urandom_range(1, 40);
      case (kind)
        0: teclas = '0;
        1: teclas = 16'h0001 << $urandom_range(0, 15);
        2: teclas = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        3: teclas = 16'h0001 << $urandom_range(0, 15);
        default: begin rst_n = 1'b0; tick(); rst_n = 1'b1; end
      endcase
      if (kind == 3) begin
        logic [15:0] m;
        m = teclas;
        for (int k = 0; k < hold; k++) begin
          teclas = ($urandom_range(0, 1) == 1) ? m : '0;
          tick();
        end
      end else ticks(hold);
    end

    // Reset from whatever state the random traffic left.
    rst_n = 1'b0;
    ticks(2);
    check_reset("reset_rand");
    rst_n = 1'b1;
    teclas = '0;
    ticks(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
